// File: rtl/echo_request_input_pkg.sv
// Shared EchoRequest pipe definitions: word layout, tag values and field widths.
// The serializer at the far end of the pipe uses the same definitions.
package echo_request_input_pkg;

  localparam int unsigned TAG_W  = 32;
  localparam int unsigned METH_W = 32;
  localparam int unsigned V_W    = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = TAG_W + METH_W + V_W;

  localparam logic [TAG_W-1:0] ECHO_TAG_SAY  = 32'd1;
  localparam logic [TAG_W-1:0] ECHO_TAG_SAY2 = 32'd2;

  typedef struct packed {
    logic [METH_W-1:0] meth;
    logic [V_W-1:0]    v;
  } echo_say_t;

  typedef struct packed {
    logic [METH_W-1:0] meth;
    logic [V_W-1:0]    v;
  } echo_say2_t;

  typedef union packed {
    echo_say_t  say;
    echo_say2_t say2;
  } echo_req_u;

  // Tag sits in the low bits, method payload above it.
  typedef struct packed {
    echo_req_u        payload;
    logic [TAG_W-1:0] tag;
  } echo_request_data_t;

endpackage

// File: rtl/echo_request_input_if.sv
// Pipe enqueue, say/say2 call and statistics signals of the EchoRequest receive side.
interface echo_request_input_if;
  import echo_request_input_pkg::*;

  logic              pipe_enq__ENA;
  logic [DATA_W-1:0] pipe_enq_v;
  logic              pipe_enq__RDY;

  logic              say__ENA;
  logic [METH_W-1:0] say_meth;
  logic [V_W-1:0]    say_v;
  logic              say__RDY;

  logic              say2__ENA;
  logic [METH_W-1:0] say2_meth;
  logic [V_W-1:0]    say2_v;
  logic              say2__RDY;

  logic [CNT_W-1:0]  say_count;
  logic [CNT_W-1:0]  say2_count;
  logic [CNT_W-1:0]  bad_tag_count;
  logic [TAG_W-1:0]  last_bad_tag;

  modport slave (
    input  pipe_enq__ENA, pipe_enq_v, say__RDY, say2__RDY,
    output pipe_enq__RDY,
    output say__ENA, say_meth, say_v,
    output say2__ENA, say2_meth, say2_v,
    output say_count, say2_count, bad_tag_count, last_bad_tag
  );

  modport master (
    output pipe_enq__ENA, pipe_enq_v, say__RDY, say2__RDY,
    input  pipe_enq__RDY,
    input  say__ENA, say_meth, say_v,
    input  say2__ENA, say2_meth, say2_v,
    input  say_count, say2_count, bad_tag_count, last_bad_tag
  );

endinterface

// File: rtl/echo_pipe_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO, no bypass; head word is read combinationally.
module echo_pipe_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)      occ <= occ + OCC_W'(1);
      else if (do_pop && !do_push) occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/echo_request_input.sv
// EchoRequest pipe receiver: buffers tagged words and replays them as say/say2 calls,
// dropping and counting words with unknown tags.
module echo_request_input
  import echo_request_input_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                  CLK,
  input logic                  nRST,
  echo_request_input_if.slave  bus
);

  echo_request_data_t head;
  logic [DATA_W-1:0]  head_raw;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               head_say;
  logic               head_say2;
  logic               head_bad;
  logic               say_done;
  logic               say2_done;

  logic [CNT_W-1:0]   say_count;
  logic [CNT_W-1:0]   say2_count;
  logic [CNT_W-1:0]   bad_tag_count;
  logic [TAG_W-1:0]   last_bad_tag;

  echo_pipe_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (push),
    .pop   (pop),
    .din   (bus.pipe_enq_v),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = echo_request_data_t'(head_raw);

  // Head classification; everything is held off while reset is asserted.
  assign head_say  = nRST && !fifo_empty && (head.tag == ECHO_TAG_SAY);
  assign head_say2 = nRST && !fifo_empty && (head.tag == ECHO_TAG_SAY2);
  assign head_bad  = nRST && !fifo_empty && !head_say && !head_say2;

  assign say_done  = head_say && bus.say__RDY;
  assign say2_done = head_say2 && bus.say2__RDY;
  assign pop       = say_done || say2_done || head_bad;

  assign bus.pipe_enq__RDY = nRST && !fifo_full;
  assign push              = bus.pipe_enq__ENA && bus.pipe_enq__RDY;

  assign bus.say__ENA  = head_say;
  assign bus.say_meth  = head_say ? head.payload.say.meth : '0;
  assign bus.say_v     = head_say ? head.payload.say.v : '0;
  assign bus.say2__ENA = head_say2;
  assign bus.say2_meth = head_say2 ? head.payload.say2.meth : '0;
  assign bus.say2_v    = head_say2 ? head.payload.say2.v : '0;

  // Call counters wrap; the drop counter saturates.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      say_count     <= '0;
      say2_count    <= '0;
      bad_tag_count <= '0;
      last_bad_tag  <= '0;
    end else begin
      if (say_done)  say_count  <= say_count + CNT_W'(1);
      if (say2_done) say2_count <= say2_count + CNT_W'(1);
      if (head_bad) begin
        last_bad_tag <= head.tag;
        if (bad_tag_count != '1) bad_tag_count <= bad_tag_count + CNT_W'(1);
      end
    end
  end

  assign bus.say_count     = say_count;
  assign bus.say2_count    = say2_count;
  assign bus.bad_tag_count = bad_tag_count;
  assign bus.last_bad_tag  = last_bad_tag;

endmodule
